mem_bus_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_pick.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory/IO bus arbiter:
// FSM state encodings, master identifiers, the read data returned
// on an aborted access, and the bundle latched for the granted master.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'h0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between the CPU (m0) and the auxiliary
// master (m1).
// Build option ARB_RR_EN: when defined, ties go to the master that did not
// win last time (round-robin); when undefined, the CPU always wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_m0Req,
    input  logic i_m1Req,
    input  logic i_last,
    output logic o_anyReq,
    output logic o_grant
);

`ifdef ARB_RR_EN
    // Round-robin: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        o_anyReq = i_m0Req | i_m1Req;
        if (i_m0Req && i_m1Req) begin
            o_grant = ~i_last;
        end else if (i_m1Req) begin
            o_grant = M_AUX;
        end else begin
            o_grant = M_CPU;
        end
    end
`else
    logic w_unusedLast;

    // The previous-winner history has no influence under fixed priority
    assign w_unusedLast = i_last;

    // Fixed priority: the auxiliary master wins only when the CPU is silent
    always_comb begin
        o_anyReq = i_m0Req | i_m1Req;
        if (i_m1Req && !i_m0Req) begin
            o_grant = M_AUX;
        end else begin
            o_grant = M_CPU;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory/IO bus arbiter. One master is granted in IDLE, its
// address/data/we are latched, the bus is driven in ACCESS until mem_ack
// or a timeout, and a one-cycle ready pulse is returned in RESP.
// The RESP bubble before the next IDLE gives the other master a chance
// to win arbitration.
// Build option ARB_RR_EN selects round-robin arbitration (see arb_pick);
// without it the CPU has fixed priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t        r_state;
    state_t        w_nextState;
    logic          r_grant;
    logic          r_last;
    bus_req_t      r_req;
    logic [TW-1:0] r_tmoCnt;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_anyReq;
    logic          w_pick;
    logic          w_inAccess;
    logic          w_ackHit;
    logic          w_tmoHit;
    bus_req_t      w_m0Bundle;
    bus_req_t      w_m1Bundle;

    assign w_m0Bundle.we    = m0_we;
    assign w_m0Bundle.addr  = m0_addr;
    assign w_m0Bundle.wdata = m0_wdata;
    assign w_m1Bundle.we    = m1_we;
    assign w_m1Bundle.addr  = m1_addr;
    assign w_m1Bundle.wdata = m1_wdata;

    // mem_ack counts only while the bus is actually being driven; ack wins
    // over the timeout limit when both land in the same cycle
    assign w_inAccess = (r_state == ST_ACCESS);
    assign w_ackHit   = w_inAccess && mem_ack;
    assign w_tmoHit   = w_inAccess && !mem_ack && (r_tmoCnt == TW'(TIMEOUT - 1));

    arb_pick u_pick (
        .i_m0Req  (m0_req),
        .i_m1Req  (m1_req),
        .i_last   (r_last),
        .o_anyReq (w_anyReq),
        .o_grant  (w_pick)
    );

    // State register; reset forces IDLE at once so mem_en drops asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> RESP on
    // ack or timeout, RESP always returns to IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_ackHit || w_tmoHit) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so they change only on
    // the clock edge (or immediately on reset)
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_req.addr;
        mem_wdata = r_req.wdata;
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m0_err    = 1'b0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;
        m1_err    = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_req.we;
            end
            ST_RESP: begin
                if (r_grant == M_CPU) begin
                    m0_ready = 1'b1;
                    m0_rdata = r_rdata;
                    m0_err   = r_err;
                end else begin
                    m1_ready = 1'b1;
                    m1_rdata = r_rdata;
                    m1_err   = r_err;
                end
            end
            default: begin
            end
        endcase
    end

    // Grant/request latch: master inputs are only looked at in IDLE, so a
    // master changing or dropping its request mid-access has no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= M_CPU;
            r_last  <= M_AUX;
            r_req   <= '0;
        end else if ((r_state == ST_IDLE) && w_anyReq) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_req   <= (w_pick == M_AUX) ? w_m1Bundle : w_m0Bundle;
        end
    end

    // Timeout counter: cleared on grant, counts ACCESS cycles without ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmoCnt <= '0;
        end else if ((r_state == ST_IDLE) && w_anyReq) begin
            r_tmoCnt <= '0;
        end else if (w_inAccess && !w_ackHit && !w_tmoHit) begin
            r_tmoCnt <= r_tmoCnt + TW'(1);
        end
    end

    // Response capture: read data on ack (zero for writes), or the error
    // pattern plus err flag on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_ackHit) begin
            r_rdata <= r_req.we ? 32'h0 : mem_rdata;
            r_err   <= 1'b0;
        end else if (w_tmoHit) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
        end
    end

endmodule
